// File: rtl/dac_spi_transmitter_if.sv
// Sample request and serial-link status bundle for dac_spi_transmitter.
// master drives the request side; slave is the transmitter.
interface dac_spi_transmitter_if;
  logic        start;
  logic [11:0] sample;
  logic [3:0]  channel;
  logic        busy;
  logic        done;
  logic        dac_cs_n;
  logic        spi_sck;
  logic        spi_mosi;

  modport master (
    output start, sample, channel,
    input  busy, done, dac_cs_n, spi_sck, spi_mosi
  );

  modport slave (
    input  start, sample, channel,
    output busy, done, dac_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/dac_spi_transmitter.sv
// Serialises one 32-bit DAC write frame per start strobe over SPI (mode 0, MSB first).
// Every output is a flop; chip select stays low for 66 SCK half-periods per frame.
module dac_spi_transmitter #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter logic [3:0]  CMD         = 4'b0011
) (
  input logic                  clk,
  input logic                  rst,
  dac_spi_transmitter_if.slave bus
);

  localparam logic [3:0] DivLast = 4'(HALF_PERIOD - 1);
  localparam logic [5:0] BitLast = 6'd31;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_q, bit_d;
  logic [3:0]  div_q, div_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] frame;
  logic        div_last;

  assign frame    = {8'h00, CMD, bus.channel, bus.sample, 4'h0};
  assign div_last = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (bus.start) begin
          shreg_d = frame;
          mosi_d  = frame[31];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 4'd1;
        end
      end

      // SHIFT opens with a low phase; MOSI only advances as SCK falls.
      StShift: begin
        if (div_last) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == BitLast) begin
              mosi_d  = 1'b0;
              state_d = StHold;
            end else begin
              shreg_d = {shreg_q[30:0], 1'b0};
              mosi_d  = shreg_q[30];
              bit_d   = bit_q + 6'd1;
            end
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end

      StHold: begin
        if (div_last) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          div_d = div_q + 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dac_cs_n = cs_n_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dac_spi_transmitter.sv
// Randomised scoreboard bench: two transmitters (half-period 2 and 1) share clock and reset;
// a per-instance monitor decodes each frame from the pins and checks it against the queue.
module tb_dac_spi_transmitter;

  logic clk;
  logic rst;

  logic [1:0]  start_s;
  logic [11:0] sample_s [2];
  logic [3:0]  ch_s     [2];
  logic [1:0]  cs_w, sck_w, mosi_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  dac_spi_transmitter_if bus0 ();
  dac_spi_transmitter_if bus1 ();

  dac_spi_transmitter #(.HALF_PERIOD(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dac_spi_transmitter #(.HALF_PERIOD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.start   = start_s[0];
  assign bus0.sample  = sample_s[0];
  assign bus0.channel = ch_s[0];
  assign bus1.start   = start_s[1];
  assign bus1.sample  = sample_s[1];
  assign bus1.channel = ch_s[1];

  assign cs_w[0]   = bus0.dac_cs_n;
  assign sck_w[0]  = bus0.spi_sck;
  assign mosi_w[0] = bus0.spi_mosi;
  assign busy_w[0] = bus0.busy;
  assign done_w[0] = bus0.done;
  assign cs_w[1]   = bus1.dac_cs_n;
  assign sck_w[1]  = bus1.spi_sck;
  assign mosi_w[1] = bus1.spi_mosi;
  assign busy_w[1] = bus1.busy;
  assign done_w[1] = bus1.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  // Reference frame built straight from the field layout.
  function automatic logic [31:0] frame_of(input logic [3:0] c, input logic [11:0] s);
    return {8'h00, 4'b0011, c, s, 4'h0};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int H = (k == 0) ? 2 : 1;
    logic [31:0] exp_q[$];
    int          done_cnt;
    int          last_gap;

    initial begin
      logic [31:0] rx, exp;
      int          rises, low_cnt, high_cnt;
      logic        prev_sck, prev_cs, prev_mosi, glitch;
      done_cnt = 0;
      last_gap = 0;
      rx = '0; rises = 0; low_cnt = 0; high_cnt = 0;
      prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; glitch = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          rx = '0; rises = 0; low_cnt = 0; high_cnt = 0;
          prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0; glitch = 1'b0;
          continue;
        end
        if (busy_w[k] !== !cs_w[k]) glitch = 1'b1;
        if (cs_w[k]) begin
          if (sck_w[k] !== 1'b0 || mosi_w[k] !== 1'b0) glitch = 1'b1;
          if (!prev_cs) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL frame[%0d]: frame %h ended with no outstanding request, want none", k,
                       rx);
            end else begin
              exp = exp_q.pop_front();
              if (done_w[k] !== 1'b1 || rx !== exp || rises != 32 || low_cnt != 66 * H ||
                  glitch) begin
                errors++;
                $display({"FAIL frame[%0d]: done=%b data=%h rises=%0d cs_low=%0d glitch=%b, ",
                          "want done=1 data=%h rises=32 cs_low=%0d glitch=0"},
                         k, done_w[k], rx, rises, low_cnt, glitch, exp, 66 * H);
              end
            end
            if (done_w[k] === 1'b1) done_cnt++;
            glitch = 1'b0;
          end else if (done_w[k] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done[%0d]: done=%b with chip select idle, want 0", k,
                     done_w[k]);
          end
          high_cnt++;
        end else begin
          if (prev_cs) begin
            last_gap = high_cnt;
            high_cnt = 0;
            rx = '0;
            rises = 0;
            low_cnt = 0;
          end
          low_cnt++;
          if (sck_w[k] && !prev_sck) begin
            rx = {rx[30:0], mosi_w[k]};
            rises++;
          end
          if (sck_w[k] && prev_sck && mosi_w[k] !== prev_mosi) glitch = 1'b1;
          if (done_w[k] !== 1'b0) glitch = 1'b1;
        end
        prev_sck  = sck_w[k];
        prev_cs   = cs_w[k];
        prev_mosi = mosi_w[k];
      end
    end
  end

  task automatic push_exp(input int k, input logic [31:0] e);
    if (k == 0) g_mon[0].exp_q.push_back(e);
    else g_mon[1].exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name, input int k);
    checks++;
    if (cs_w[k] !== 1'b1 || sck_w[k] !== 1'b0 || mosi_w[k] !== 1'b0 || busy_w[k] !== 1'b0 ||
        done_w[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s[%0d]: cs_n=%b sck=%b mosi=%b busy=%b done=%b, want 1 0 0 0 0", name, k,
               cs_w[k], sck_w[k], mosi_w[k], busy_w[k], done_w[k]);
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_w[k] !== 1'b0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_w[k] !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout[%0d]: busy=%b after %0d cycles, want 0", k, busy_w[k], n);
    end
  endtask

  task automatic wait_done(input int k, input bit scramble);
    int n = 0;
    while (done_w[k] !== 1'b1 && n < 3000) begin
      if (scramble) begin
        sample_s[k] = 12'($urandom);
        ch_s[k]     = 4'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    if (done_w[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: done=%b after %0d cycles, want 1", k, done_w[k], n);
    end
  endtask

  // Issue start in the current cycle (caller guarantees the transmitter is idle).
  task automatic pulse_start(input int k, input logic [11:0] s, input logic [3:0] c,
                             input logic [31:0] e);
    sample_s[k] = s;
    ch_s[k]     = c;
    start_s[k]  = 1'b1;
    push_exp(k, e);
    @(posedge clk); #1;
    start_s[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [11:0] s, input logic [3:0] c,
                      input logic [31:0] e);
    wait_idle(k);
    pulse_start(k, s, c, e);
  endtask

  initial begin
    logic [11:0] s;
    logic [3:0]  c;
    int          d0, k;

    rst = 1'b0;
    start_s = '0;
    for (int i = 0; i < 2; i++) begin
      sample_s[i] = '0;
      ch_s[i]     = '0;
    end

    // Reset state, with start held during reset.
    repeat (2) @(posedge clk);
    #1;
    start_s = 2'b11;
    @(posedge clk); #1;
    check_idle("reset", 0);
    check_idle("reset", 1);
    start_s = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("start_in_reset", 0);
    check_idle("start_in_reset", 1);

    // Directed frames at both half-periods.
    send(0, 12'hA5C, 4'h0, 32'h0030A5C0);
    wait_done(0, 1'b0);
    send(1, 12'hFFF, 4'hF, 32'h003FFFF0);
    wait_done(1, 1'b0);

    // Start during an active frame is dropped.
    d0 = g_mon[0].done_cnt;
    s = 12'($urandom);
    c = 4'($urandom);
    send(0, s, c, frame_of(c, s));
    repeat (2 * 2 + 9 * 2 * 2) @(posedge clk);
    #1;
    sample_s[0] = ~s;
    ch_s[0]     = ~c;
    start_s[0]  = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(0, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (g_mon[0].done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d done pulses, want 1", g_mon[0].done_cnt - d0);
    end

    // Reset in the middle of SHIFT aborts the frame without a done pulse.
    s = 12'($urandom);
    c = 4'($urandom);
    send(0, s, c, frame_of(c, s));
    repeat (2 * 2 + 17 * 2 * 2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("abort", 0);
    rst = 1'b1;
    g_mon[0].exp_q.delete();
    s = 12'($urandom);
    c = 4'($urandom);
    send(0, s, c, frame_of(c, s));
    wait_done(0, 1'b0);

    // Back-to-back frames: start issued in the done cycle.
    for (int i = 0; i < 2; i++) begin
      s = 12'($urandom);
      c = 4'($urandom);
      send(i, s, c, frame_of(c, s));
      wait_done(i, 1'b0);
      s = 12'($urandom);
      c = 4'($urandom);
      pulse_start(i, s, c, frame_of(c, s));
      wait_done(i, 1'b0);
      checks++;
      if ((i == 0 ? g_mon[0].last_gap : g_mon[1].last_gap) != 1) begin
        errors++;
        $display("FAIL back_to_back_gap[%0d]: cs_n high %0d cycles, want 1", i,
                 (i == 0 ? g_mon[0].last_gap : g_mon[1].last_gap));
      end
    end

    // Inputs churning every cycle of a frame must not reach the wire.
    for (int i = 0; i < 2; i++) begin
      s = 12'($urandom);
      c = 4'($urandom);
      send(i, s, c, frame_of(c, s));
      wait_done(i, 1'b1);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 1));
      s = 12'($urandom);
      c = 4'($urandom);
      send(k, s, c, frame_of(c, s));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end

    wait_idle(0);
    wait_idle(1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (g_mon[0].exp_q.size() != 0 || g_mon[1].exp_q.size() != 0) begin
      errors++;
      $display("FAIL drained: %0d/%0d frames never completed, want 0/0", g_mon[0].exp_q.size(),
               g_mon[1].exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
